// File: rtl/priority_encoder_8to3_pkg.sv
// Shared sizes and types for the 8-to-3 priority encoder.
package priority_encoder_8to3_pkg;
    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;
    typedef logic [IDX_W-1:0] req_idx_t;
endpackage

// File: rtl/priority_encoder_8to3_core.sv
// Combinational priority core: index of the highest asserted request line.
module priority_encoder_8to3_core
    import priority_encoder_8to3_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    output req_idx_t           idx,
    output logic               any
);
    always_comb begin
        idx = '0;
        any = |req;
        // Highest line first, so lower lines only matter when all above are clear.
        casez (req)
            8'b1???????: idx = 3'd7;
            8'b01??????: idx = 3'd6;
            8'b001?????: idx = 3'd5;
            8'b0001????: idx = 3'd4;
            8'b00001???: idx = 3'd3;
            8'b000001??: idx = 3'd2;
            8'b0000001?: idx = 3'd1;
            default:     idx = 3'd0;
        endcase
    end
endmodule

// File: rtl/priority_encoder_8to3.sv
// 8-input priority encoder (D7 highest) with registered index and valid flag.
module priority_encoder_8to3
    import priority_encoder_8to3_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           D0,
    input  logic           D1,
    input  logic           D2,
    input  logic           D3,
    input  logic           D4,
    input  logic           D5,
    input  logic           D6,
    input  logic           D7,
    output logic [IDX_W-1:0] Y,
    output logic           valid
);
    logic [NUM_REQ-1:0] req;
    req_idx_t           idx;
    logic               any;
    req_idx_t           y_d, y_q;
    logic               valid_d, valid_q;

    assign req = {D7, D6, D5, D4, D3, D2, D1, D0};

    priority_encoder_8to3_core u_core (
        .req (req),
        .idx (idx),
        .any (any)
    );

    always_comb begin
        y_d     = idx;
        valid_d = any;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign Y     = y_q;
    assign valid = valid_q;
endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Directed-vector bench for priority_encoder_8to3; expected {valid,Y} hand-computed.
module tb_priority_encoder_8to3;
    logic       clk;
    logic       rst;
    logic [7:0] d_vec;
    logic [2:0] y;
    logic       valid;
    int         checks;
    int         failures;

    priority_encoder_8to3 dut (
        .clk   (clk),
        .rst   (rst),
        .D0    (d_vec[0]),
        .D1    (d_vec[1]),
        .D2    (d_vec[2]),
        .D3    (d_vec[3]),
        .D4    (d_vec[4]),
        .D5    (d_vec[5]),
        .D6    (d_vec[6]),
        .D7    (d_vec[7]),
        .Y     (y),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got valid=%b Y=%b, expected valid=%b Y=%b",
                     tag, got[3], got[2:0], exp[3], exp[2:0]);
        end
    endtask

    // Drive inputs, let one rising edge pass, then sample away from the edge.
    task automatic apply(input string tag, input logic r, input logic [7:0] v,
                         input logic [3:0] exp);
        rst   = r;
        d_vec = v;
        @(posedge clk);
        #1;
        $display("txn %-12s rst=%b D=%b -> valid=%b Y=%b", tag, r, v, valid, y);
        check(tag, {valid, y}, exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        d_vec    = 8'hFF;

        apply("rst_edge1",  1'b1, 8'hFF,        4'b0_000);
        apply("rst_edge2",  1'b1, 8'hFF,        4'b0_000);
        apply("rst_rel_0",  1'b0, 8'b0000_0000, 4'b0_000);

        apply("low_d0",     1'b0, 8'b0000_0001, 4'b1_000);
        apply("low_d1",     1'b0, 8'b0000_0011, 4'b1_001);
        apply("low_d2",     1'b0, 8'b0000_0111, 4'b1_010);
        apply("low_d3",     1'b0, 8'b0000_1111, 4'b1_011);

        apply("clear",      1'b0, 8'b0000_0000, 4'b0_000);
        apply("high_d4",    1'b0, 8'b0001_0000, 4'b1_100);
        apply("high_d5",    1'b0, 8'b0011_0000, 4'b1_101);
        apply("high_d6",    1'b0, 8'b0111_0000, 4'b1_110);
        apply("high_d7",    1'b0, 8'b1111_0000, 4'b1_111);

        apply("prio_d2",    1'b0, 8'b0000_0100, 4'b1_010);
        apply("prio_d6d2",  1'b0, 8'b0100_0100, 4'b1_110);
        apply("prio_d7d0",  1'b0, 8'b1000_0001, 4'b1_111);
        apply("prio_d5d4",  1'b0, 8'b0011_1010, 4'b1_101);

        apply("d0_only",    1'b0, 8'b0000_0001, 4'b1_000);
        apply("all_zero",   1'b0, 8'b0000_0000, 4'b0_000);

        apply("pre_rst_d7", 1'b0, 8'b1000_0000, 4'b1_111);
        apply("mid_rst",    1'b1, 8'b1000_0000, 4'b0_000);
        apply("post_rst",   1'b0, 8'b1000_0000, 4'b1_111);
        apply("all_ones",   1'b0, 8'hFF,        4'b1_111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
